// File: rtl/sram_mem_ctrl.sv
// Splits a 32-bit MEM-stage load/store into two 16-bit SRAM accesses and stalls the pipeline meanwhile.
// Optional `SRAM_BOUND_CHECK_EN adds an addr_err output and rejects out-of-range or misaligned requests.
module sram_mem_ctrl #(
    parameter int WAIT_CYCLES = 3,
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
`ifdef SRAM_BOUND_CHECK_EN
    ,
    output logic               addr_err
`endif
);

    localparam int         WORD_W   = SRAM_AW - 1;
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               op_wr_q, op_wr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic               req;
    logic               addr_bad;
    logic [WORD_W-1:0]  word;

    assign req = rd_en | wr_en;

`ifdef SRAM_BOUND_CHECK_EN
    logic [29:0] word_full;
    logic        err_q, err_d;

    assign word_full = 30'((address - 32'(BASE_ADDR)) >> 2);
    assign word      = word_full[WORD_W-1:0];
    assign addr_bad  = (address < 32'(BASE_ADDR)) || (|word_full[29:WORD_W]) || (|address[1:0]);
    assign addr_err  = (state_q == DONE) && err_q;
`else
    // Without bound checking, high offset bits are simply dropped so addresses wrap.
    assign word     = WORD_W'((address - 32'(BASE_ADDR)) >> 2);
    assign addr_bad = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_wr_q     <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
`ifdef SRAM_BOUND_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
`ifdef SRAM_BOUND_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = addr_bad ? DONE : LO;
            LO:      if (cnt_q == LAST_CNT) state_d = HI;
            HI:      if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = '0;
        op_wr_d     = op_wr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
`ifdef SRAM_BOUND_CHECK_EN
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    op_wr_d = wr_en;
                    wdata_d = write_data;
`ifdef SRAM_BOUND_CHECK_EN
                    err_d   = addr_bad;
`endif
                    if (!addr_bad) begin
                        sram_addr_d = {word, 1'b0};
                    end else if (!wr_en) begin
                        rdata_d = '0;
                    end
                end
            end
            LO: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d       = '0;
                    sram_addr_d = {sram_addr_q[SRAM_AW-1:1], 1'b1};
                    if (!op_wr_q) rdata_d[15:0] = sram_dq_in;
                end
            end
            HI: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (!op_wr_q) rdata_d[31:16] = sram_dq_in;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = '0;
        ready       = 1'b0;
        case (state_q)
            IDLE: ready = !req;
            LO: begin
                if (op_wr_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[15:0];
                end
            end
            HI: begin
                if (op_wr_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[31:16];
                end
            end
            DONE:    ready = 1'b1;
            default: ;
        endcase
    end

    assign read_data = rdata_q;
    assign sram_addr = sram_addr_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboard bench for sram_mem_ctrl: expected SRAM write beats and load results are queued at
// request time and compared when the controller produces them.
module tb_sram_mem_ctrl;

  localparam int WC = 3;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en, wr_en;
  logic [31:0]   address, write_data;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_in;
  logic          sram_we_n;
`ifdef SRAM_BOUND_CHECK_EN
  logic          addr_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [15:0]     mem [0:255];
  logic [34:0]     beat_q [$];
  logic [31:0]     rd_q [$];
  logic [31:0]     last_rd = '0;

  always #5 clk = ~clk;

  sram_mem_ctrl #(.WAIT_CYCLES(WC), .BASE_ADDR(1024), .SRAM_AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n)
`ifdef SRAM_BOUND_CHECK_EN
    ,
    .addr_err    (addr_err)
`endif
  );

  // Small asynchronous-read SRAM covering half-word addresses 0..255.
  assign sram_dq_in = (sram_addr < AW'(256)) ? mem[sram_addr[7:0]] : 16'h0000;

  always @(posedge clk) begin
    if (!rst && !sram_we_n && sram_dq_oe && sram_addr < AW'(256)) mem[sram_addr[7:0]] = sram_dq_out;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every cycle with the write strobe low must match the next queued write beat.
  always @(negedge clk) begin
    if (!rst && !sram_we_n) begin
      if (beat_q.size() == 0) check("unexpected_write", {29'b0, sram_dq_oe, sram_addr, sram_dq_out}, '1);
      else check("wr_beat", {29'b0, sram_dq_oe, sram_addr, sram_dq_out}, {29'b0, beat_q.pop_front()});
    end
  end

  task automatic push_beats(input logic [AW-1:0] sa, input logic [31:0] wdata);
    for (int i = 0; i < WC; i++) beat_q.push_back({1'b1, sa, wdata[15:0]});
    for (int i = 0; i < WC; i++) beat_q.push_back({1'b1, sa[AW-1:1], 1'b1, wdata[31:16]});
  endtask

  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [AW-1:0] exp_sa, input logic [31:0] exp_rd,
                            input int exp_lat, input logic exp_err, input bit hold);
    int k;
    logic [31:0] e;
    @(negedge clk);
    rd_en = rd; wr_en = wr; address = addr; write_data = wdata;
    if (wr && exp_lat > 1) push_beats(exp_sa, wdata);
    if (rd && !wr) rd_q.push_back(exp_rd);
    #1 check({tag, "_req_ready"}, 64'(ready), 64'd0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        address    = 32'h0000_0F00;
        write_data = ~wdata;
      end
      #1;
    end while (!ready && k < 40);
    check({tag, "_latency"}, 64'(k), 64'(exp_lat));
    if (rd && !wr) begin
      e = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hxxxx_xxxx;
      check({tag, "_rdata"}, 64'(read_data), 64'(e));
      last_rd = e;
    end else begin
      check({tag, "_rdata_hold"}, 64'(read_data), 64'(last_rd));
    end
`ifdef SRAM_BOUND_CHECK_EN
    check({tag, "_addr_err"}, 64'(addr_err), 64'(exp_err));
`endif
    if (!hold) begin
      rd_en = 1'b0;
      wr_en = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[5] = 16'hA5A5;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_ready",  64'(ready),       64'd1);
    check("rst_we_n",   64'(sram_we_n),   64'd1);
    check("rst_oe",     64'(sram_dq_oe),  64'd0);
    check("rst_rdata",  64'(read_data),   64'd0);
    check("rst_addr",   64'(sram_addr),   64'd0);
    check("rst_dq_out", 64'(sram_dq_out), 64'd0);
`ifdef SRAM_BOUND_CHECK_EN
    check("rst_addr_err", 64'(addr_err), 64'd0);
`endif

    // Store aborted by reset at the start of its first high-half cycle.
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1032; write_data = 32'h1111_2222;
    push_beats(AW'(4), 32'h1111_2222);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_we_n", 64'(sram_we_n),  64'd1);
    check("abort_oe",   64'(sram_dq_oe), 64'd0);
    check("abort_addr", 64'(sram_addr),  64'd0);
    wr_en = 1'b0;
    #1 check("abort_ready", 64'(ready), 64'd1);
    check("abort_beats_left", 64'(beat_q.size()), 64'd3);
    beat_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("abort_idle_ready", 64'(ready), 64'd1);
    check("abort_mem4", 64'(mem[4]), 64'h2222);
    check("abort_mem5", 64'(mem[5]), 64'hA5A5);

    run_access("st_beef", 1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, AW'(4), 32'h0, 2*WC+1, 1'b0, 1'b0);
    check("st_mem4", 64'(mem[4]), 64'hBEEF);
    check("st_mem5", 64'(mem[5]), 64'hDEAD);
    run_access("ld_beef", 1'b1, 1'b0, 32'd1032, 32'h0, AW'(4), 32'hDEAD_BEEF, 2*WC+1, 1'b0, 1'b0);
    run_access("both", 1'b1, 1'b1, 32'd1036, 32'h1234_5678, AW'(6), 32'h0, 2*WC+1, 1'b0, 1'b0);
    run_access("ld_1234", 1'b1, 1'b0, 32'd1036, 32'h0, AW'(6), 32'h1234_5678, 2*WC+1, 1'b0, 1'b1);
    run_access("b2b_ld", 1'b1, 1'b0, 32'd1032, 32'h0, AW'(4), 32'hDEAD_BEEF, 2*WC+1, 1'b0, 1'b0);

`ifdef SRAM_BOUND_CHECK_EN
    run_access("oob_ld", 1'b1, 1'b0, 32'd1000, 32'h0, AW'(0), 32'h0, 1, 1'b1, 1'b0);
    run_access("ld_ok", 1'b1, 1'b0, 32'd1036, 32'h0, AW'(6), 32'h1234_5678, 2*WC+1, 1'b0, 1'b0);
    run_access("mis_ld", 1'b1, 1'b0, 32'd1034, 32'h0, AW'(0), 32'h0, 1, 1'b1, 1'b0);
    run_access("big_st", 1'b0, 1'b1, 32'd525320, 32'hCAFE_F00D, AW'(0), 32'h0, 1, 1'b1, 1'b0);
    run_access("ld_after", 1'b1, 1'b0, 32'd1032, 32'h0, AW'(4), 32'hDEAD_BEEF, 2*WC+1, 1'b0, 1'b0);
`else
    run_access("wrap_st", 1'b0, 1'b1, 32'd525320, 32'hCAFE_F00D, AW'(4), 32'h0, 2*WC+1, 1'b0, 1'b0);
    run_access("wrap_ld", 1'b1, 1'b0, 32'd1032, 32'h0, AW'(4), 32'hCAFE_F00D, 2*WC+1, 1'b0, 1'b0);
`endif

    @(negedge clk);
    #1;
    check("end_ready", 64'(ready), 64'd1);
    check("end_beats_left", 64'(beat_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Memory-stage controller that sits upstream of the MEM/WB pipeline register.
- Turns a single-cycle 32-bit load/store request from the MEM stage into two sequential 16-bit accesses on an external SRAM.
- Holds `ready` low to freeze the pipeline until the access completes.
- Supplies the 32-bit load result that the MEM stage forwards as the data-memory result into MEM/WB.

Parameters:
- WAIT_CYCLES, 3, cycles each 16-bit half-access is held on the SRAM bus (legal range 1..15).
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- SRAM_AW, 18, SRAM address width.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- rd_en  input  1  load request from MEM stage (held until ready)
- wr_en  input  1  store request from MEM stage (held until ready)
- address  input  32  byte address of access
- write_data  input  32  store data
- read_data  output  32  load result, valid while ready=1 after a read
- ready  output  1  0 = freeze pipeline; 1 = access complete or no access
- sram_addr  output  SRAM_AW  SRAM half-word address
- sram_dq_out  output  16  data driven to SRAM
- sram_dq_oe  output  1  1 = controller drives SRAM data bus
- sram_dq_in  input  16  data returned by SRAM
- sram_we_n  output  1  active-low SRAM write enable

Behaviour:
- Reset (asynchronous, any time including mid-access):
  - state=IDLE, counter=0, read_data=0.
  - sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
  - The access in flight is abandoned; no partial retry.
- Address mapping: word = (address - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits.
  - Low half at sram_addr = {word,0}.
  - High half at sram_addr = {word,1}.
  - Little-endian: bits 15:0 go to the low half.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if rd_en|wr_en at the rising edge -> LO, counter=0, operation latched (wr_en has priority if both high).
  - LO: drive the low-half address. Counter increments each cycle. After WAIT_CYCLES cycles in LO -> HI, counter=0.
  - HI: drive the high-half address for WAIT_CYCLES cycles -> DONE.
  - DONE: one cycle -> IDLE unconditionally. A request still high in the following IDLE cycle is treated as a new access, because the pipeline advanced on the DONE edge.
- Write:
  - During LO and HI: sram_we_n=0 and sram_dq_oe=1.
  - sram_dq_out = write_data[15:0] in LO, write_data[31:16] in HI.
  - Otherwise we_n=1 and oe=0.
- Read:
  - sram_we_n=1, oe=0.
  - read_data[15:0] is captured from sram_dq_in on the last LO cycle.
  - read_data[31:16] is captured on the last HI cycle.
  - read_data holds its value until the next read captures.
- ready (combinational):
  - 1 when (state==IDLE and !rd_en and !wr_en) or state==DONE.
  - 0 in LO/HI, and 0 in IDLE when a request is present.
- Latency: request visible in IDLE at cycle 0 -> ready=1 during cycle 2*WAIT_CYCLES+1, i.e. 7 with default.
- address/write_data are latched at the IDLE->LO edge. Changes during the access are ignored.
- sram_addr in IDLE/DONE holds the last driven value.

Optional Feature:
- Macro: SRAM_BOUND_CHECK_EN.
- Defined:
  - Adds output port addr_err (1 bit).
  - A request with address < BASE_ADDR, or word >= 2^(SRAM_AW-1), or address[1:0] != 0 goes IDLE -> DONE directly, with no SRAM activity (we_n stays 1).
  - In that DONE cycle: addr_err=1 and read_data=0 for reads; addr_err=0 otherwise.
- Not defined:
  - No addr_err port; no checks are made.
  - Out-of-range addresses wrap by truncation.

Test Plan:
- Reset then idle with rd_en=wr_en=0 -> ready=1, we_n=1, oe=0, read_data=0.
- Store 0xDEADBEEF to 1032:
  - Cycles 1-3: sram_addr=4, dq_out=0xBEEF, we_n=0.
  - Cycles 4-6: sram_addr=5, dq_out=0xDEAD.
  - ready=1 in cycle 7, then IDLE.
- Load from 1032, SRAM model returns 0xBEEF at 4 and 0xDEAD at 5 -> ready=0 for cycles 0-6; read_data=0xDEADBEEF with ready=1 in cycle 7; we_n=1 throughout.
- rd_en and wr_en both high to 1036 with write_data=0x12345678 -> write occurs (addr 6=0x5678, addr 7=0x1234); read_data unchanged.
- Assert rst in cycle 4 of a store -> we_n=1, oe=0, state IDLE immediately. After release with no request, ready=1. SRAM addr 5 is never written.
- With SRAM_BOUND_CHECK_EN, load from 1000 -> no LO/HI cycles; ready=1 and addr_err=1 in cycle 1; read_data=0.
